// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: debug channel inputs, board switches
// and display outputs of the seven-segment scan driver.
`timescale 1ns/1ps
interface seg_scan_display_if #(
    parameter int N_CH  = 8,
    parameter int W     = 32,
    parameter int N_DIG = 4
);
    localparam int SEL_W = $clog2(N_CH);
    localparam int NIB   = W / 4;
    localparam int NPG   = (NIB + N_DIG - 1) / N_DIG;
    localparam int PG_W  = (NPG > 1) ? $clog2(NPG) : 1;
    localparam int NBY   = W / 8;
    localparam int BY_W  = (NBY > 1) ? $clog2(NBY) : 1;

    logic [N_CH*W-1:0] ch_data;
    logic [SEL_W-1:0]  ch_sel;
    logic [PG_W-1:0]   page;
    logic [BY_W-1:0]   byte_sel;
    logic              freeze;
    logic              blank_lz;
    logic [6:0]        seg_n;
    logic [N_DIG-1:0]  dig_n;
    logic [7:0]        led;

    modport master (
        output ch_data, ch_sel, page, byte_sel, freeze, blank_lz,
        input  seg_n, dig_n, led
    );

    modport slave (
        input  ch_data, ch_sel, page, byte_sel, freeze, blank_lz,
        output seg_n, dig_n, led
    );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display: snapshot of a selected debug channel shown on
// multiplexed active-low seven-segment digits and an LED byte.
`timescale 1ns/1ps
module seg_scan_display #(
    parameter int N_CH      = 8,
    parameter int W         = 32,
    parameter int N_DIG     = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input logic              sys_clk,
    input logic              rst_n,
    seg_scan_display_if.slave bus
);
    localparam int SEL_W = $clog2(N_CH);
    localparam int NIB   = W / 4;
    localparam int NPG   = (NIB + N_DIG - 1) / N_DIG;
    localparam int PG_W  = (NPG > 1) ? $clog2(NPG) : 1;
    localparam int NBY   = W / 8;
    localparam int BY_W  = (NBY > 1) ? $clog2(NBY) : 1;
    localparam int D_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int P_W   = $clog2(SCAN_DIV);
    localparam int SY_W  = SEL_W + PG_W + BY_W + 2;

    logic [SY_W-1:0]  sy1;
    logic [SY_W-1:0]  sy2;
    logic [SEL_W-1:0] ch_sel_s;
    logic [PG_W-1:0]  page_s;
    logic [BY_W-1:0]  byte_sel_s;
    logic             freeze_s;
    logic             blank_lz_s;

    logic [W-1:0]     chan;
    logic [W-1:0]     snap;
    logic [P_W-1:0]   pre;
    logic [D_W-1:0]   d;

    logic [3:0]       wnib [N_DIG];
    logic [N_DIG-1:0] wval;
    logic [N_DIG-1:0] zrun;
    logic             z;

    logic [3:0]       cur_nib;
    logic             cur_val;
    logic             cur_zero;
    logic             blank;
    logic [6:0]       seg_d;
    logic [N_DIG-1:0] dig_d;
    logic [7:0]       led_d;

    logic [6:0]       seg_q;
    logic [N_DIG-1:0] dig_q;
    logic [7:0]       led_q;

    function automatic logic [6:0] decode(input logic [3:0] x);
        logic [6:0] s;
        unique case (x)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h58;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign {ch_sel_s, page_s, byte_sel_s, freeze_s, blank_lz_s} = sy2;

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sy1 <= '0;
            sy2 <= '0;
        end else begin
            sy1 <= {bus.ch_sel, bus.page, bus.byte_sel,
                    bus.freeze, bus.blank_lz};
            sy2 <= sy1;
        end
    end

    // Channel selector; unused select codes fall back to channel 0.
    always_comb begin
        chan = bus.ch_data[W-1:0];
        for (int k = 1; k < N_CH; k++) begin
            if (ch_sel_s == SEL_W'(k)) begin
                chan = bus.ch_data[k*W +: W];
            end
        end
    end

    // Snapshot tracks the channel until frozen.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (!freeze_s) begin
            snap <= chan;
        end
    end

    // Slot prescaler and digit index.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            d   <= '0;
        end else if (pre == P_W'(SCAN_DIV - 1)) begin
            pre <= '0;
            d   <= (d == D_W'(N_DIG - 1)) ? '0 : d + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Nibbles of the current window, and per digit whether it and
    // every higher in-range nibble of the window are zero.
    always_comb begin
        for (int k = 0; k < N_DIG; k++) begin
            wnib[k] = 4'h0;
            wval[k] = 1'b0;
        end
        zrun = '0;
        z    = 1'b1;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            for (int i = 0; i < NIB; i++) begin
                if (int'(page_s) * N_DIG + k == i) begin
                    wnib[k] = snap[i*4 +: 4];
                    wval[k] = 1'b1;
                end
            end
            z       = z & (wnib[k] == 4'h0);
            zrun[k] = z;
        end
    end

    // Segment pattern and digit enable for the active slot.
    always_comb begin
        cur_nib  = wnib[0];
        cur_val  = wval[0];
        cur_zero = 1'b0;
        dig_d    = '1;
        for (int k = 0; k < N_DIG; k++) begin
            if (d == D_W'(k)) begin
                cur_nib  = wnib[k];
                cur_val  = wval[k];
                cur_zero = (k != 0) && zrun[k];
                if (pre >= P_W'(BLANK_CYC)) begin
                    dig_d[k] = 1'b0;
                end
            end
        end
        blank = !cur_val || (blank_lz_s && cur_zero);
        seg_d = blank ? 7'h7F : decode(cur_nib);
    end

    // LED byte select; unused codes show zero.
    always_comb begin
        led_d = 8'h00;
        for (int b = 0; b < NBY; b++) begin
            if (byte_sel_s == BY_W'(b)) begin
                led_d = snap[b*8 +: 8];
            end
        end
    end

    // Registered display outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'h7F;
            dig_q <= '1;
            led_q <= 8'h00;
        end else begin
            seg_q <= seg_d;
            dig_q <= dig_d;
            led_q <= led_d;
        end
    end

    assign bus.seg_n = seg_q;
    assign bus.dig_n = dig_q;
    assign bus.led   = led_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: randomized scoreboard bench for the
// seven-segment scan driver, two parameter sets.
`timescale 1ns/1ps
module tb_seg_scan_display;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam logic [6:0] DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [7:0]      led;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_display_if #(.N_CH(4), .W(32), .N_DIG(4)) ba ();
    seg_scan_display_if #(.N_CH(3), .W(40), .N_DIG(3)) bb ();

    seg_scan_display #(
        .N_CH(4), .W(32), .N_DIG(4), .SCAN_DIV(SD), .BLANK_CYC(BC)
    ) u0 (
        .sys_clk(clk), .rst_n(rst_n), .bus(ba.slave)
    );

    seg_scan_display #(
        .N_CH(3), .W(40), .N_DIG(3), .SCAN_DIV(SD), .BLANK_CYC(BC)
    ) u1 (
        .sys_clk(clk), .rst_n(rst_n), .bus(bb.slave)
    );

    int vec = 0;
    int miss = 0;
    frame_t fq0 [$];
    frame_t fq1 [$];

    logic [63:0] cha [4];
    logic [63:0] chb [3];
    int sel_a, pg_a, bs_a;
    bit frz_a, blz_a;
    logic [63:0] snap_a;
    int sel_b, pg_b, bs_b;
    bit blz_b;

    function automatic logic [3:0] gdig(input int w);
        return (w == 0) ? ba.dig_n : {1'b1, bb.dig_n};
    endfunction

    function automatic logic [6:0] gseg(input int w);
        return (w == 0) ? ba.seg_n : bb.seg_n;
    endfunction

    function automatic logic [7:0] gled(input int w);
        return (w == 0) ? ba.led : bb.led;
    endfunction

    // Expected display content of a value shown through a window.
    function automatic frame_t model(input logic [63:0] v, input int w,
                                     input int nd, input int pg,
                                     input bit blz, input int bs);
        frame_t f;
        int nib, n, top;
        bit allz;
        nib = w / 4;
        f.seg = '1;
        for (int k = 0; k < nd; k++) begin
            n = pg * nd + k;
            top = pg * nd + nd - 1;
            if (top > nib - 1) top = nib - 1;
            if (n < nib) begin
                allz = 1'b1;
                for (int j = n; j <= top; j++)
                    if (((v >> (4 * j)) & 64'hF) != 0) allz = 1'b0;
                if (blz && k != 0 && allz) f.seg[k] = 7'h7F;
                else f.seg[k] = DEC[4'((v >> (4 * n)) & 64'hF)];
            end
        end
        f.led = (bs < w / 8) ? 8'((v >> (8 * bs)) & 64'hFF) : 8'h00;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Observe one full refresh starting at digit 0 and compare it.
    task automatic run_frame(input int which, input frame_t f);
        int nd, t, k, lows, prev, lastk;
        int lit [4];
        bit segok [4];
        logic [6:0] bad [4];
        bit seqok, ledok;
        logic [7:0] badled;
        logic [3:0] dg;
        nd = (which == 0) ? 4 : 3;
        for (int j = 0; j < 4; j++) begin
            lit[j] = 0;
            segok[j] = 1'b1;
            bad[j] = f.seg[j];
        end
        seqok = 1'b1;
        ledok = 1'b1;
        badled = f.led;
        prev = -1;
        lastk = -1;
        t = 0;
        while (gdig(which) == 4'b1110 && t < 100) begin
            @(negedge clk);
            t++;
        end
        while (gdig(which) != 4'b1110 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            vec++;
            miss++;
            $display("FAIL frame_sync dut%0d: got no digit0 expected one", which);
            return;
        end
        for (int c = 0; c < nd * SD; c++) begin
            dg = gdig(which);
            k = -1;
            lows = 0;
            for (int j = 0; j < 4; j++) begin
                if (!dg[j]) begin
                    lows++;
                    k = j;
                end
            end
            if (gled(which) != f.led) begin
                ledok = 1'b0;
                badled = gled(which);
            end
            if (lows > 1 || k >= nd) begin
                seqok = 1'b0;
            end else if (k >= 0) begin
                if (prev >= 0 && prev != k) seqok = 1'b0;
                if (prev < 0 && k != lastk + 1) seqok = 1'b0;
                lit[k]++;
                lastk = k;
                if (gseg(which) != f.seg[k]) begin
                    segok[k] = 1'b0;
                    bad[k] = gseg(which);
                end
            end
            prev = k;
            @(negedge clk);
        end
        for (int j = 0; j < nd; j++) begin
            vec++;
            if (!segok[j] || lit[j] != SD - BC) begin
                miss++;
                $display("FAIL seg dut%0d d%0d: got %h lit %0d expected %h lit %0d",
                         which, j, bad[j], lit[j], f.seg[j], SD - BC);
            end
        end
        vec++;
        if (!ledok) begin
            miss++;
            $display("FAIL led dut%0d: got %h expected %h", which, badled, f.led);
        end
        vec++;
        if (!seqok) begin
            miss++;
            $display("FAIL dig_seq dut%0d: got bad enable order expected one-hot 0..%0d",
                     which, nd - 1);
        end
    endtask

    initial begin : mon0
        frame_t f;
        forever begin
            @(negedge clk);
            if (fq0.size() > 0) begin
                f = fq0[0];
                run_frame(0, f);
                if (fq0.size() > 0) fq0.delete(0);
            end
        end
    end

    initial begin : mon1
        frame_t f;
        forever begin
            @(negedge clk);
            if (fq1.size() > 0) begin
                f = fq1[0];
                run_frame(1, f);
                if (fq1.size() > 0) fq1.delete(0);
            end
        end
    end

    task automatic wait_empty(input int which);
        int t;
        t = 0;
        while (((which == 0) ? fq0.size() : fq1.size()) > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (((which == 0) ? fq0.size() : fq1.size()) > 0) begin
            vec++;
            miss++;
            $display("FAIL frame_timeout dut%0d: got pending frame expected consumed", which);
            if (which == 0) fq0.delete();
            else fq1.delete();
        end
    endtask

    task automatic apply_a(input int sel, input int pg, input int bs,
                           input bit frz, input bit blz);
        if (frz && !frz_a) snap_a = cha[(sel_a < 4) ? sel_a : 0];
        sel_a = sel;
        pg_a = pg;
        bs_a = bs;
        frz_a = frz;
        blz_a = blz;
        ba.ch_data = {cha[3][31:0], cha[2][31:0], cha[1][31:0], cha[0][31:0]};
        ba.ch_sel = 2'(sel);
        ba.page = 1'(pg);
        ba.byte_sel = 2'(bs);
        ba.freeze = frz;
        ba.blank_lz = blz;
    endtask

    task automatic apply_b(input int sel, input int pg, input int bs,
                           input bit blz);
        sel_b = sel;
        pg_b = pg;
        bs_b = bs;
        blz_b = blz;
        bb.ch_data = {chb[2][39:0], chb[1][39:0], chb[0][39:0]};
        bb.ch_sel = 2'(sel);
        bb.page = 2'(pg);
        bb.byte_sel = 3'(bs);
        bb.freeze = 1'b0;
        bb.blank_lz = blz;
    endtask

    task automatic check_a();
        logic [63:0] v;
        repeat (6) @(negedge clk);
        v = frz_a ? snap_a : cha[(sel_a < 4) ? sel_a : 0];
        fq0.push_back(model(v, 32, 4, pg_a, blz_a, bs_a));
        wait_empty(0);
    endtask

    task automatic check_b();
        logic [63:0] v;
        repeat (6) @(negedge clk);
        v = chb[(sel_b < 3) ? sel_b : 0];
        fq1.push_back(model(v, 40, 3, pg_b, blz_b, bs_b));
        wait_empty(1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int t;
        frz_a = 1'b0;
        sel_a = 0;
        snap_a = '0;
        for (int c = 0; c < 4; c++) cha[c] = '0;
        for (int c = 0; c < 3; c++) chb[c] = '0;
        cha[0] = 64'($urandom);
        cha[1] = 64'h1234_5678;
        cha[2] = 64'h0000_0A05;
        cha[3] = 64'($urandom);
        chb[0] = 64'h98_7654_3210;
        chb[1] = 64'h00_0000_0F00;
        chb[2] = {32'($urandom), 32'($urandom)} >> 24;
        apply_a(0, 0, 0, 0, 0);
        apply_b(0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg_a", 32'(ba.seg_n), 32'h7F);
        chk("rst_dig_a", 32'(ba.dig_n), 32'hF);
        chk("rst_led_a", 32'(ba.led), 32'h00);
        chk("rst_seg_b", 32'(bb.seg_n), 32'h7F);
        chk("rst_dig_b", 32'(bb.dig_n), 32'h7);
        chk("rst_led_b", 32'(bb.led), 32'h00);
        rst_n = 1'b1;

        apply_a(1, 0, 2, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("led_latency", 32'(ba.led), 32'h34);
        check_a();
        apply_a(1, 1, 2, 0, 0);
        check_a();
        apply_a(2, 0, 0, 0, 1);
        check_a();
        apply_a(2, 0, 0, 0, 0);
        check_a();

        apply_a(1, 0, 2, 0, 0);
        repeat (6) @(negedge clk);
        apply_a(1, 0, 2, 1, 0);
        repeat (6) @(negedge clk);
        cha[1] = 64'hFFFF_FFFF;
        apply_a(1, 0, 2, 1, 0);
        check_a();
        apply_a(1, 0, 2, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("unfreeze_led", 32'(ba.led), 32'hFF);
        check_a();

        t = 0;
        while (ba.dig_n != 4'b1011 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("midslot_sync", 32'(ba.dig_n), 32'hB);
        rst_n = 1'b0;
        #1;
        chk("midrst_seg_a", 32'(ba.seg_n), 32'h7F);
        chk("midrst_dig_a", 32'(ba.dig_n), 32'hF);
        chk("midrst_led_a", 32'(ba.led), 32'h00);
        chk("midrst_dig_b", 32'(bb.dig_n), 32'h7);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rel_blank", 32'(ba.dig_n), 32'hF);
        @(posedge clk);
        @(negedge clk);
        chk("rel_first_lit", 32'(ba.dig_n), 32'hE);

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++)
                cha[c] = 64'($urandom >> $urandom_range(0, 28));
            apply_a($urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
            check_a();
        end

        apply_b(3, 3, 6, 0);
        check_b();
        apply_b(3, 0, 4, 1);
        check_b();
        apply_b(1, 1, 1, 1);
        check_b();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++)
                chb[c] = {32'($urandom), 32'($urandom)} >> $urandom_range(24, 60);
            apply_b($urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            check_b();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
